dac_routing: RTL and testbench
==============================

DAC_ROUTING -- requirements
Module: dac_routing

Interface
REQ-001 The module SHALL have a parameter WIDTH, default 32, giving the data width of all sample ports.
REQ-002 The module SHALL have a parameter SETTLE_CYCLES, default 16, giving the park duration in clocks on a channel change; legal range 1..255.
REQ-003 The module SHALL have a parameter PARK_VALUE, default 0 (WIDTH bits), giving the value driven on an idle or parked channel.
REQ-004 clk  input  1  single system clock; all logic rising-edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 dac_i  input  WIDTH  sample stream to be routed.
REQ-007 dac_valid_i  input  1  dac_i carries a new sample this cycle.
REQ-008 user_cntr  input  1  requested channel: 0 = channel A, 1 = channel B.
REQ-009 dac_a_o  output  WIDTH  channel A sample, registered.
REQ-010 dac_b_o  output  WIDTH  channel B sample, registered.
REQ-011 dac_a_valid_o  output  1  a new sample was written to dac_a_o on this edge.
REQ-012 dac_b_valid_o  output  1  a new sample was written to dac_b_o on this edge.
REQ-013 switching_o  output  1  high while both channels are parked for a channel change.
REQ-014 switch_count_o  output  16  number of completed channel changes, saturating.

Function
REQ-015 The block SHALL hold an internal active_sel register and a two-state FSM: ROUTE and PARK.
REQ-016 In ROUTE with user_cntr == active_sel, on an edge with dac_valid_i=1, the active output SHALL load dac_i and its valid SHALL be 1, giving 1-cycle latency.
REQ-017 In ROUTE, on an edge with dac_valid_i=0, the active output SHALL hold its last value and its valid SHALL be 0.
REQ-018 In ROUTE, the inactive output SHALL equal PARK_VALUE and its valid SHALL be 0.
REQ-019 In ROUTE, on an edge where user_cntr != active_sel, the FSM SHALL enter PARK and load the counter with SETTLE_CYCLES-1.
REQ-020 On that same edge, both outputs SHALL load PARK_VALUE, both valids SHALL be 0, switching_o SHALL be 1, and the dac_i sample SHALL be dropped.
REQ-021 In PARK with counter != 0, the counter SHALL decrement, both outputs SHALL stay at PARK_VALUE, and valids SHALL be 0; user_cntr changes SHALL be ignored.
REQ-022 In PARK with counter == 0, active_sel SHALL load the current user_cntr, the FSM SHALL return to ROUTE, and switching_o SHALL go to 0.
REQ-023 In the PARK-exit case of REQ-022, outputs SHALL remain parked that edge; routing SHALL resume on the next edge.
REQ-024 switching_o SHALL be high for exactly SETTLE_CYCLES clocks per change.
REQ-025 The sample dac_valid_i SHALL NOT be forwarded to any output while in PARK.
REQ-026 If user_cntr at PARK exit equals the old active_sel, the block SHALL return to the old channel, having served the full park.
REQ-027 On the PARK-exit edge, switch_count_o SHALL increment only if the new active_sel differs from the old one.
REQ-028 switch_count_o SHALL saturate at 0xFFFF and SHALL NOT wrap.
REQ-029 SETTLE_CYCLES = 1 SHALL give a single parked cycle: enter and exit on consecutive edges.

Reset
REQ-030 While rst=1, the block SHALL load: FSM = ROUTE, active_sel = 0 (A), counter = 0.
REQ-031 While rst=1, the block SHALL load: dac_a_o = dac_b_o = PARK_VALUE, both valids = 0, switching_o = 0, switch_count_o = 0.
REQ-032 rst SHALL take priority over all other inputs, including mid-PARK; reset during PARK SHALL abort the change without incrementing switch_count_o.
REQ-033 If user_cntr=1 at reset release, the first post-reset edge SHALL enter PARK per REQ-019.

Verification (WIDTH=32, SETTLE_CYCLES=4, PARK_VALUE=0)
REQ-034 The bench SHALL check, after reset: user_cntr=0, dac_i=12, valid=1 -> next edge dac_a_o=12, dac_a_valid_o=1, dac_b_o=0, dac_b_valid_o=0.
REQ-035 The bench SHALL check, from steady A: user_cntr 0->1, dac_i=16 held valid -> switching_o high 4 cycles, both outputs 0; then one parked edge; then dac_b_o=16 with valid; switch_count_o=1.
REQ-036 The bench SHALL check: user_cntr 0->1 then back to 0 during PARK -> full 4-cycle park, return to A, switch_count_o unchanged.
REQ-037 The bench SHALL check: rst asserted on the 2nd PARK cycle -> all outputs 0 next edge, active_sel=A, switch_count_o=0.
REQ-038 The bench SHALL check: valid toggled 1,0,1 with dac_i=5,6,7 in ROUTE -> dac_a_o=5,5,7, valid=1,0,1.
REQ-039 The bench SHALL check: force 65537 changes (or preload the counter) -> switch_count_o stays 0xFFFF.

Source files
------------

// File: rtl/dac_routing.sv
// Routes one sample stream to DAC channel A or B, parking both channels at
// PARK_VALUE for SETTLE_CYCLES clocks whenever the requested channel changes.
module dac_routing #(
    parameter int               WIDTH         = 32,
    parameter int               SETTLE_CYCLES = 16,
    parameter logic [WIDTH-1:0] PARK_VALUE    = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] dac_i,
    input  logic             dac_valid_i,
    input  logic             user_cntr,
    output logic [WIDTH-1:0] dac_a_o,
    output logic [WIDTH-1:0] dac_b_o,
    output logic             dac_a_valid_o,
    output logic             dac_b_valid_o,
    output logic             switching_o,
    output logic [15:0]      switch_count_o
);

    typedef enum logic {ROUTE, PARK} state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t           state, state_nxt;
    logic             active_sel, active_sel_nxt;
    logic [7:0]       settle_cnt, settle_cnt_nxt;
    logic [WIDTH-1:0] dac_a_nxt, dac_b_nxt;
    logic             dac_a_valid_nxt, dac_b_valid_nxt;
    logic             switching_nxt;
    logic [15:0]      switch_count, switch_count_nxt;

    assign switch_count_o = switch_count;

    always_comb begin
        state_nxt        = state;
        active_sel_nxt   = active_sel;
        settle_cnt_nxt   = settle_cnt;
        dac_a_nxt        = dac_a_o;
        dac_b_nxt        = dac_b_o;
        dac_a_valid_nxt  = 1'b0;
        dac_b_valid_nxt  = 1'b0;
        switching_nxt    = switching_o;
        switch_count_nxt = switch_count;

        case (state)
            ROUTE: begin
                if (user_cntr != active_sel) begin
                    // Channel change requested: the sample on this edge is dropped.
                    state_nxt      = PARK;
                    settle_cnt_nxt = SETTLE_LOAD;
                    dac_a_nxt      = PARK_VALUE;
                    dac_b_nxt      = PARK_VALUE;
                    switching_nxt  = 1'b1;
                end else if (!active_sel) begin
                    dac_b_nxt = PARK_VALUE;
                    if (dac_valid_i) begin
                        dac_a_nxt       = dac_i;
                        dac_a_valid_nxt = 1'b1;
                    end
                end else begin
                    dac_a_nxt = PARK_VALUE;
                    if (dac_valid_i) begin
                        dac_b_nxt       = dac_i;
                        dac_b_valid_nxt = 1'b1;
                    end
                end
            end

            PARK: begin
                dac_a_nxt = PARK_VALUE;
                dac_b_nxt = PARK_VALUE;
                if (settle_cnt != 8'd0) begin
                    settle_cnt_nxt = settle_cnt - 8'd1;
                end else begin
                    // Outputs stay parked on the exit edge; routing resumes next edge.
                    state_nxt      = ROUTE;
                    active_sel_nxt = user_cntr;
                    switching_nxt  = 1'b0;
                    if ((user_cntr != active_sel) && (switch_count != 16'hFFFF))
                        switch_count_nxt = switch_count + 16'd1;
                end
            end

            default: state_nxt = ROUTE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ROUTE;
            active_sel    <= 1'b0;
            settle_cnt    <= 8'd0;
            dac_a_o       <= PARK_VALUE;
            dac_b_o       <= PARK_VALUE;
            dac_a_valid_o <= 1'b0;
            dac_b_valid_o <= 1'b0;
            switching_o   <= 1'b0;
            switch_count  <= 16'd0;
        end else begin
            state         <= state_nxt;
            active_sel    <= active_sel_nxt;
            settle_cnt    <= settle_cnt_nxt;
            dac_a_o       <= dac_a_nxt;
            dac_b_o       <= dac_b_nxt;
            dac_a_valid_o <= dac_a_valid_nxt;
            dac_b_valid_o <= dac_b_valid_nxt;
            switching_o   <= switching_nxt;
            switch_count  <= switch_count_nxt;
        end
    end

endmodule

// File: tb/tb_dac_routing.sv
// Directed bench for dac_routing with WIDTH=32, SETTLE_CYCLES=4, PARK_VALUE=0.
module tb_dac_routing;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dac_i;
    logic        dac_valid_i;
    logic        user_cntr;
    logic [31:0] dac_a_o;
    logic [31:0] dac_b_o;
    logic        dac_a_valid_o;
    logic        dac_b_valid_o;
    logic        switching_o;
    logic [15:0] switch_count_o;

    int vector_count = 0;
    int fail_count   = 0;

    dac_routing #(
        .WIDTH         (32),
        .SETTLE_CYCLES (4),
        .PARK_VALUE    (32'd0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .dac_i          (dac_i),
        .dac_valid_i    (dac_valid_i),
        .user_cntr      (user_cntr),
        .dac_a_o        (dac_a_o),
        .dac_b_o        (dac_b_o),
        .dac_a_valid_o  (dac_a_valid_o),
        .dac_b_valid_o  (dac_b_valid_o),
        .switching_o    (switching_o),
        .switch_count_o (switch_count_o)
    );

    always #5 clk = ~clk;

    // Drive inputs, take one rising edge, and settle 1ns past it before sampling.
    task automatic applyStimulus(input logic r, input logic [31:0] d,
                                 input logic v, input logic u);
        rst         = r;
        dac_i       = d;
        dac_valid_i = v;
        user_cntr   = u;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vector_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [31:0] a, input logic av,
                            input logic [31:0] b, input logic bv, input logic sw,
                            input logic [15:0] cnt);
        checkOutput({tag, ".a"},   dac_a_o,              a);
        checkOutput({tag, ".av"},  {31'd0, dac_a_valid_o}, {31'd0, av});
        checkOutput({tag, ".b"},   dac_b_o,              b);
        checkOutput({tag, ".bv"},  {31'd0, dac_b_valid_o}, {31'd0, bv});
        checkOutput({tag, ".sw"},  {31'd0, switching_o}, {31'd0, sw});
        checkOutput({tag, ".cnt"}, {16'd0, switch_count_o}, {16'd0, cnt});
    endtask

    initial begin
        rst = 1'b1; dac_i = '0; dac_valid_i = 1'b0; user_cntr = 1'b0;

        // Reset state
        applyStimulus(1'b1, 32'd99, 1'b1, 1'b1);
        applyStimulus(1'b1, 32'd99, 1'b1, 1'b1);
        checkAll("reset", 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 16'd0);

        // First sample routed to A with one cycle latency
        applyStimulus(1'b0, 32'd12, 1'b1, 1'b0);
        checkAll("first_a", 32'd12, 1'b1, 32'd0, 1'b0, 1'b0, 16'd0);

        // Valid toggling: hold value when valid is low
        applyStimulus(1'b0, 32'd5, 1'b1, 1'b0);
        checkAll("vt5", 32'd5, 1'b1, 32'd0, 1'b0, 1'b0, 16'd0);
        applyStimulus(1'b0, 32'd6, 1'b0, 1'b0);
        checkAll("vt6", 32'd5, 1'b0, 32'd0, 1'b0, 1'b0, 16'd0);
        applyStimulus(1'b0, 32'd7, 1'b1, 1'b0);
        checkAll("vt7", 32'd7, 1'b1, 32'd0, 1'b0, 1'b0, 16'd0);

        // A -> B: four switching cycles, one parked exit edge, then B routes
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'd16, 1'b1, 1'b1);
            checkAll($sformatf("ab_park%0d", i), 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 16'd0);
        end
        applyStimulus(1'b0, 32'd16, 1'b1, 1'b1);
        checkAll("ab_exit", 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 16'd1);
        applyStimulus(1'b0, 32'd16, 1'b1, 1'b1);
        checkAll("ab_route", 32'd0, 1'b0, 32'd16, 1'b1, 1'b0, 16'd1);

        // B -> A so the abort test starts from A
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'd16, 1'b1, 1'b0);
        checkAll("ba_exit", 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 16'd2);
        applyStimulus(1'b0, 32'd16, 1'b1, 1'b0);
        checkAll("ba_route", 32'd16, 1'b1, 32'd0, 1'b0, 1'b0, 16'd2);

        // Request B then revert to A during park: full park, back to A, count unchanged
        applyStimulus(1'b0, 32'd20, 1'b1, 1'b1);
        checkAll("rev_park0", 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 16'd2);
        for (int i = 1; i < 4; i++) begin
            applyStimulus(1'b0, 32'd20, 1'b1, 1'b0);
            checkAll($sformatf("rev_park%0d", i), 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 16'd2);
        end
        applyStimulus(1'b0, 32'd20, 1'b1, 1'b0);
        checkAll("rev_exit", 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 16'd2);
        applyStimulus(1'b0, 32'd21, 1'b1, 1'b0);
        checkAll("rev_route", 32'd21, 1'b1, 32'd0, 1'b0, 1'b0, 16'd2);

        // Reset on the second park cycle aborts the change and clears the count
        applyStimulus(1'b0, 32'd22, 1'b1, 1'b1);
        checkAll("rp_park0", 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 16'd2);
        applyStimulus(1'b1, 32'd22, 1'b1, 1'b1);
        checkAll("rp_reset", 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 16'd0);
        applyStimulus(1'b0, 32'd9, 1'b1, 1'b0);
        checkAll("rp_route_a", 32'd9, 1'b1, 32'd0, 1'b0, 1'b0, 16'd0);

        // user_cntr=1 at reset release enters park on the first edge
        applyStimulus(1'b1, 32'd9, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'd9, 1'b1, 1'b1);
        checkAll("rel_park0", 32'd0, 1'b0, 32'd0, 1'b0, 1'b1, 16'd0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'd9, 1'b1, 1'b1);
        checkAll("rel_exit", 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 16'd1);
        applyStimulus(1'b0, 32'd9, 1'b1, 1'b1);
        checkAll("rel_route_b", 32'd0, 1'b0, 32'd9, 1'b1, 1'b0, 16'd1);

        // Saturation: preload the count just below the ceiling, then change twice
        force dut.switch_count = 16'hFFFE;
        #1;
        release dut.switch_count;
        #1;
        checkOutput("sat_preload", {16'd0, switch_count_o}, 32'h0000FFFE);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'd3, 1'b1, 1'b0);
        checkOutput("sat_first", {16'd0, switch_count_o}, 32'h0000FFFF);
        applyStimulus(1'b0, 32'd3, 1'b1, 1'b0);
        checkAll("sat_route_a", 32'd3, 1'b1, 32'd0, 1'b0, 1'b0, 16'hFFFF);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 32'd4, 1'b1, 1'b1);
        checkOutput("sat_hold", {16'd0, switch_count_o}, 32'h0000FFFF);
        applyStimulus(1'b0, 32'd4, 1'b1, 1'b1);
        checkAll("sat_route_b", 32'd0, 1'b0, 32'd4, 1'b1, 1'b0, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, fail_count);
        $finish;
    end

endmodule
